// File: rtl/doppler_pkg.sv
// Shared constants for the Doppler frame monitor: error codes, FSM states and
// the magnitude width rule.
package doppler_pkg;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_SHORT = 2'd1;
  localparam logic [1:0] ERR_LONG  = 2'd2;
  localparam logic [1:0] ERR_CH    = 2'd3;

  typedef enum logic [0:0] {
    ST_ACCUM   = 1'b0,
    ST_DISCARD = 1'b1
  } state_e;

  // |I|+|Q| of two H-bit signed values never exceeds 2^H, so H+1 bits suffice.
  function automatic int mag_width(input int h);
    return h + 1;
  endfunction

endpackage

// File: rtl/doppler_cmag.sv
// Combinational L1 magnitude |I|+|Q| of one complex sample.
module doppler_cmag
  import doppler_pkg::*;
#(
  parameter int H = 16
) (
  input  logic [H-1:0]              i_val,
  input  logic [H-1:0]              q_val,
  output logic [mag_width(H)-1:0]   mag
);

  logic [H:0] i_ext, q_ext, i_abs, q_abs;

  // Extending by one bit before negating keeps |-2^(H-1)| exact.
  always_comb begin
    i_ext = {i_val[H-1], i_val};
    q_ext = {q_val[H-1], q_val};
    i_abs = i_val[H-1] ? -i_ext : i_ext;
    q_abs = q_val[H-1] ? -q_ext : q_ext;
    mag   = i_abs + q_abs;
  end

endmodule

// File: rtl/doppler_frame_monitor.sv
// Per-frame peak finder and frame-length checker on the Doppler FFT output
// stream; emits one result record per frame over a valid/ready handshake.
module doppler_frame_monitor
  import doppler_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_BINS   = 64,
  parameter  int NUM_CH     = 4,
  localparam int H          = DATA_WIDTH / 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BIN_W      = $clog2(NUM_BINS),
  localparam int MAG_W      = mag_width(H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tlast,
  input  logic [CH_W-1:0]       s_tuser,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CH_W-1:0]       m_ch,
  output logic [BIN_W-1:0]      m_peak_bin,
  output logic [MAG_W-1:0]      m_peak_mag,
  output logic [15:0]           m_seq,
  output logic [1:0]            m_err,
  output logic [15:0]           err_short_cnt,
  output logic [15:0]           err_long_cnt
);

  logic              state_q, state_d;
  logic [BIN_W-1:0]  bin_cnt_q, bin_cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              ch_err_q, ch_err_d;
  logic [BIN_W-1:0]  peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
  logic [15:0]       seq_q [NUM_CH];
  logic [15:0]       seq_d [NUM_CH];

  logic              m_valid_q, m_valid_d;
  logic [CH_W-1:0]   m_ch_q, m_ch_d;
  logic [BIN_W-1:0]  m_peak_bin_q, m_peak_bin_d;
  logic [MAG_W-1:0]  m_peak_mag_q, m_peak_mag_d;
  logic [15:0]       m_seq_q, m_seq_d;
  logic [1:0]        m_err_q, m_err_d;
  logic [15:0]       err_short_q, err_short_d;
  logic [15:0]       err_long_q, err_long_d;

  logic [MAG_W-1:0]  beat_mag;
  logic              accept, first_beat, last_bin, ch_err_now;
  logic [CH_W-1:0]   frame_ch, seq_idx;

  doppler_cmag #(.H(H)) u_cmag (
    .i_val (s_tdata[DATA_WIDTH-1:H]),
    .q_val (s_tdata[H-1:0]),
    .mag   (beat_mag)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    s_tready     = (state_q == ST_DISCARD) || !m_valid_q || m_ready;
    accept       = s_tvalid && s_tready;
    first_beat   = (bin_cnt_q == '0);
    last_bin     = (bin_cnt_q == BIN_W'(NUM_BINS - 1));
    frame_ch     = first_beat ? s_tuser : ch_q;
    ch_err_now   = !first_beat && (s_tuser != ch_q);
    seq_idx      = (int'(frame_ch) >= NUM_CH) ? CH_W'(NUM_CH - 1) : frame_ch;

    state_d      = state_q;
    bin_cnt_d    = bin_cnt_q;
    ch_d         = ch_q;
    ch_err_d     = ch_err_q;
    peak_bin_d   = peak_bin_q;
    peak_mag_d   = peak_mag_q;
    seq_d        = seq_q;
    m_valid_d    = m_valid_q;
    m_ch_d       = m_ch_q;
    m_peak_bin_d = m_peak_bin_q;
    m_peak_mag_d = m_peak_mag_q;
    m_seq_d      = m_seq_q;
    m_err_d      = m_err_q;
    err_short_d  = err_short_q;
    err_long_d   = err_long_q;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    if (accept && state_q == ST_DISCARD) begin
      if (s_tlast) state_d = ST_ACCUM;
    end else if (accept) begin
      ch_d      = frame_ch;
      ch_err_d  = (!first_beat && ch_err_q) || ch_err_now;
      bin_cnt_d = bin_cnt_q + 1'b1;
      // Strictly greater replaces the peak, so ties keep the earliest bin.
      if (first_beat || beat_mag > peak_mag_q) begin
        peak_mag_d = beat_mag;
        peak_bin_d = bin_cnt_q;
      end

      if (s_tlast || last_bin) begin
        bin_cnt_d          = '0;
        m_valid_d          = 1'b1;
        m_ch_d             = frame_ch;
        m_peak_bin_d       = peak_bin_d;
        m_peak_mag_d       = peak_mag_d;
        m_seq_d            = seq_q[seq_idx];
        seq_d[seq_idx]     = seq_q[seq_idx] + 16'd1;

        if (ch_err_d)               m_err_d = ERR_CH;
        else if (s_tlast && last_bin) m_err_d = ERR_OK;
        else if (s_tlast)           m_err_d = ERR_SHORT;
        else                        m_err_d = ERR_LONG;

        if (s_tlast && !last_bin && err_short_q != 16'hFFFF)
          err_short_d = err_short_q + 16'd1;
        if (!s_tlast && last_bin) begin
          if (err_long_q != 16'hFFFF) err_long_d = err_long_q + 16'd1;
          state_d = ST_DISCARD;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACCUM;
      bin_cnt_q    <= '0;
      ch_q         <= '0;
      ch_err_q     <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      // NOTE: the sequence file is small and must restart at zero, so it is
      // reset like ordinary flops rather than left as uninitialised storage.
      seq_q        <= '{default: '0};
      m_valid_q    <= 1'b0;
      m_ch_q       <= '0;
      m_peak_bin_q <= '0;
      m_peak_mag_q <= '0;
      m_seq_q      <= '0;
      m_err_q      <= ERR_OK;
      err_short_q  <= '0;
      err_long_q   <= '0;
    end else begin
      state_q      <= state_d;
      bin_cnt_q    <= bin_cnt_d;
      ch_q         <= ch_d;
      ch_err_q     <= ch_err_d;
      peak_bin_q   <= peak_bin_d;
      peak_mag_q   <= peak_mag_d;
      seq_q        <= seq_d;
      m_valid_q    <= m_valid_d;
      m_ch_q       <= m_ch_d;
      m_peak_bin_q <= m_peak_bin_d;
      m_peak_mag_q <= m_peak_mag_d;
      m_seq_q      <= m_seq_d;
      m_err_q      <= m_err_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
    end
  end

  assign m_valid       = m_valid_q;
  assign m_ch          = m_ch_q;
  assign m_peak_bin    = m_peak_bin_q;
  assign m_peak_mag    = m_peak_mag_q;
  assign m_seq         = m_seq_q;
  assign m_err         = m_err_q;
  assign err_short_cnt = err_short_q;
  assign err_long_cnt  = err_long_q;

endmodule
